// File: rtl/prescaled_counter.sv
// Modulo-(limit+1) up/down/bounce counter stepped by an internal clock-enable prescaler.
// Optional registered Gray-code output enabled by defining COUNTER_GRAY_OUT_EN.
module prescaled_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned PRESCALE = 50_000_000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic [1:0]       mode_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic [WIDTH-1:0] limit_i,
    output logic [WIDTH-1:0] q_o,
`ifdef COUNTER_GRAY_OUT_EN
    output logic [WIDTH-1:0] q_gray_o,
`endif
    output logic             tick_o,
    output logic             tc_o,
    output logic             dir_o
);

    localparam int unsigned PS_W = $clog2(PRESCALE + 1);
    localparam logic [PS_W-1:0] PsLast = PS_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        ModeUp     = 2'b00,
        ModeDown   = 2'b01,
        ModeBounce = 2'b10,
        ModeHold   = 2'b11
    } mode_e;

    mode_e           mode;
    logic [PS_W-1:0] ps_q, ps_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic            tick_q, tick_d;
    logic            tc_q, tc_d;
    logic            dir_q, dir_d;

    assign mode = mode_e'(mode_i);

    always_comb begin
        ps_d   = ps_q;
        q_d    = q_q;
        dir_d  = dir_q;
        tick_d = 1'b0;
        tc_d   = 1'b0;
        if (load_i) begin
            q_d  = (load_val_i > limit_i) ? limit_i : load_val_i;
            ps_d = '0;
        end else if (en_i) begin
            if (ps_q == PsLast) begin
                ps_d   = '0;
                tick_d = 1'b1;
                case (mode)
                    ModeUp: begin
                        dir_d = 1'b0;
                        if (q_q > limit_i) begin
                            q_d = '0;
                        end else if (q_q == limit_i) begin
                            q_d  = '0;
                            tc_d = 1'b1;
                        end else begin
                            q_d = q_q + WIDTH'(1);
                        end
                    end
                    ModeDown: begin
                        dir_d = 1'b1;
                        if (q_q > limit_i) begin
                            q_d = limit_i;
                        end else if (q_q == '0) begin
                            q_d  = limit_i;
                            tc_d = 1'b1;
                        end else begin
                            q_d = q_q - WIDTH'(1);
                        end
                    end
                    ModeBounce: begin
                        // limit==0 pins q at 0; the usual limit-1 / 1 turnarounds would escape it.
                        if (q_q > limit_i) begin
                            q_d   = '0;
                            dir_d = 1'b0;
                        end else if (limit_i == '0) begin
                            q_d   = '0;
                            tc_d  = 1'b1;
                            dir_d = ~dir_q;
                        end else if (!dir_q) begin
                            if (q_q == limit_i) begin
                                q_d   = limit_i - WIDTH'(1);
                                dir_d = 1'b1;
                                tc_d  = 1'b1;
                            end else begin
                                q_d = q_q + WIDTH'(1);
                            end
                        end else begin
                            if (q_q == '0) begin
                                q_d   = WIDTH'(1);
                                dir_d = 1'b0;
                                tc_d  = 1'b1;
                            end else begin
                                q_d = q_q - WIDTH'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end else begin
                ps_d = ps_q + PS_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ps_q   <= '0;
            q_q    <= '0;
            tick_q <= 1'b0;
            tc_q   <= 1'b0;
            dir_q  <= 1'b0;
        end else begin
            ps_q   <= ps_d;
            q_q    <= q_d;
            tick_q <= tick_d;
            tc_q   <= tc_d;
            dir_q  <= dir_d;
        end
    end

`ifdef COUNTER_GRAY_OUT_EN
    logic [WIDTH-1:0] gray_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gray_q <= '0;
        end else begin
            gray_q <= q_d ^ (q_d >> 1);
        end
    end

    assign q_gray_o = gray_q;
`endif

    assign q_o    = q_q;
    assign tick_o = tick_q;
    assign tc_o   = tc_q;
    assign dir_o  = dir_q;

endmodule

// File: tb/tb_prescaled_counter.sv
// Directed bench for prescaled_counter with WIDTH=4, PRESCALE=3.
module tb_prescaled_counter;

    localparam int unsigned PRESCALE = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;
    logic [3:0] limit = '0;
    logic [3:0] q;
    logic       tick, tc, dir;
`ifdef COUNTER_GRAY_OUT_EN
    logic [3:0] q_gray;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    prescaled_counter #(
        .WIDTH   (4),
        .PRESCALE(PRESCALE)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .en_i      (en),
        .mode_i    (mode),
        .load_i    (load),
        .load_val_i(load_val),
        .limit_i   (limit),
        .q_o       (q),
`ifdef COUNTER_GRAY_OUT_EN
        .q_gray_o  (q_gray),
`endif
        .tick_o    (tick),
        .tc_o      (tc),
        .dir_o     (dir)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
`ifdef COUNTER_GRAY_OUT_EN
        check_eq("gray", {28'd0, q_gray}, {28'd0, q ^ (q >> 1)});
`endif
    endtask

    // One full prescale period; tick/tc must stay low until the last clock.
    task automatic do_step(input string tag, input logic [3:0] eq, input logic etc,
                           input logic ed);
        for (int i = 0; i < int'(PRESCALE); i++) begin
            clk1();
            if (i < int'(PRESCALE) - 1) begin
                check_eq({tag, ".tick_idle"}, {31'd0, tick}, 32'd0);
                check_eq({tag, ".tc_idle"}, {31'd0, tc}, 32'd0);
            end
        end
        check_eq({tag, ".tick"}, {31'd0, tick}, 32'd1);
        check_eq({tag, ".q"}, {28'd0, q}, {28'd0, eq});
        check_eq({tag, ".tc"}, {31'd0, tc}, {31'd0, etc});
        check_eq({tag, ".dir"}, {31'd0, dir}, {31'd0, ed});
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check_eq("rst.q", {28'd0, q}, 32'd0);
        check_eq("rst.tick", {31'd0, tick}, 32'd0);
        check_eq("rst.tc", {31'd0, tc}, 32'd0);
        check_eq("rst.dir", {31'd0, dir}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [3:0] qe;
    logic       tce;

    initial begin
        // 1: up, limit 9, 32 steps
        do_reset();
        en = 1'b1; mode = 2'b00; limit = 4'd9;
        qe = '0;
        for (int s = 0; s < 32; s++) begin
            tce = (qe == 4'd9);
            qe  = (qe == 4'd9) ? 4'd0 : qe + 4'd1;
            do_step("up", qe, tce, 1'b0);
        end

        // 2: down, limit 5
        do_reset();
        mode = 2'b01; limit = 4'd5;
        do_step("dn0", 4'd5, 1'b1, 1'b1);
        do_step("dn1", 4'd4, 1'b0, 1'b1);
        do_step("dn2", 4'd3, 1'b0, 1'b1);
        do_step("dn3", 4'd2, 1'b0, 1'b1);
        do_step("dn4", 4'd1, 1'b0, 1'b1);
        do_step("dn5", 4'd0, 1'b0, 1'b1);
        do_step("dn6", 4'd5, 1'b1, 1'b1);

        // 3: bounce, limit 3
        do_reset();
        mode = 2'b10; limit = 4'd3;
        do_step("bn0", 4'd1, 1'b0, 1'b0);
        do_step("bn1", 4'd2, 1'b0, 1'b0);
        do_step("bn2", 4'd3, 1'b0, 1'b0);
        do_step("bn3", 4'd2, 1'b1, 1'b1);
        do_step("bn4", 4'd1, 1'b0, 1'b1);
        do_step("bn5", 4'd0, 1'b0, 1'b1);
        do_step("bn6", 4'd1, 1'b1, 1'b0);

        // 4: load clamps while frozen mid-prescale; prescaler restarts from 0
        clk1();
        en = 1'b0; load = 1'b1; load_val = 4'd12; limit = 4'd7;
        clk1();
        load = 1'b0;
        check_eq("ld.q", {28'd0, q}, 32'd7);
        check_eq("ld.tick", {31'd0, tick}, 32'd0);
        check_eq("ld.dir", {31'd0, dir}, 32'd0);
        clk1();
        clk1();
        check_eq("frz.q", {28'd0, q}, 32'd7);
        check_eq("frz.tick", {31'd0, tick}, 32'd0);
        en = 1'b1; mode = 2'b00;
        do_step("ld_up", 4'd0, 1'b1, 1'b0);

        // 5: limit lowered below q, then async reset right after a tick
        limit = 4'd9; load = 1'b1; load_val = 4'd8;
        clk1();
        load = 1'b0; limit = 4'd4;
        check_eq("ld8.q", {28'd0, q}, 32'd8);
        do_step("lower", 4'd0, 1'b0, 1'b0);
        do_step("low1", 4'd1, 1'b0, 1'b0);
        do_reset();
        do_step("post_rst", 4'd1, 1'b0, 1'b0);

        // hold: prescaler runs, q/dir frozen
        mode = 2'b11;
        do_step("hold", 4'd1, 1'b0, 1'b0);

        // limit 0: out-of-range step first, then tc on every step
        mode = 2'b00; limit = 4'd0;
        do_step("lim0a", 4'd0, 1'b0, 1'b0);
        do_step("lim0b", 4'd0, 1'b1, 1'b0);
        mode = 2'b10;
        do_step("lim0c", 4'd0, 1'b1, 1'b1);

        // bounce limit 1 (enters with dir=1 from the previous step)
        limit = 4'd1;
        do_step("l1a", 4'd1, 1'b1, 1'b0);
        do_step("l1b", 4'd0, 1'b1, 1'b1);
        do_step("l1c", 4'd1, 1'b1, 1'b0);

        // 6: full 4-bit up sweep (Gray output checked on every clock when present)
        do_reset();
        mode = 2'b00; limit = 4'd15;
        qe = '0;
        for (int s = 0; s < 16; s++) begin
            tce = (qe == 4'd15);
            qe  = qe + 4'd1;
            do_step("gsweep", qe, tce, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
